// File: rtl/sram16_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram16_responder
// Description : Bus responder that completes 32-bit CPU memory requests
//               against an external asynchronous 16-bit SRAM. Each bus word
//               is two consecutive SRAM halfwords, accessed back-to-back,
//               each access held for WAIT+1 cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   a, d, we, rd      : CPU request (byte address, write data, strobes)
//   spo, ready        : read data and one-cycle completion pulse
//   sram_addr         : SRAM halfword address {a[ADDR_W:2], half}
//   sram_dq_o/_i/_oe  : SRAM data out / data in / output enable
//   sram_*_n          : active-low SRAM controls (ce, oe, we, ub, lb)
// ============================================================================
module sram16_responder #(
  parameter int ADDR_W = 19,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic [31:0]       d,
  input  logic              we,
  input  logic              rd,
  output logic [31:0]       spo,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_WR0  = 3'd3;
  localparam logic [2:0] ST_REL0 = 3'd4;
  localparam logic [2:0] ST_WR1  = 3'd5;
  localparam logic [2:0] ST_REL1 = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       spo_q, spo_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;

  logic wait_done;
  logic entering_access;
  logic unused_a_bits;

  // Address bits outside the word field are decoded upstream.
  assign unused_a_bits = ^{a[31:ADDR_W+1], a[1:0]};

  assign wait_done = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // State / register process
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      spo_q   <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      spo_q   <= spo_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state process (also latches the request and runs the wait counter)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (we || rd) begin
          word_d  = a[ADDR_W:2];
          wdata_d = d;
          // Write wins when both strobes arrive together.
          state_d = we ? ST_WR0 : ST_RD0;
        end
      end
      ST_RD0:  if (wait_done) state_d = ST_RD1;
      ST_RD1:  if (wait_done) state_d = ST_DONE;
      ST_WR0:  if (wait_done) state_d = ST_REL0;
      ST_REL0: state_d = ST_WR1;
      ST_WR1:  if (wait_done) state_d = ST_REL1;
      ST_REL1: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    entering_access = (state_d != state_q) &&
                      ((state_d == ST_RD0) || (state_d == ST_RD1) ||
                       (state_d == ST_WR0) || (state_d == ST_WR1));

    if (entering_access) begin
      cnt_d = WAIT_LOAD;
    end else if (!wait_done) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output process: outputs are computed from the next state so that the
  // registered pins line up exactly with the state they belong to.
  // --------------------------------------------------------------------------
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    dq_o_d  = dq_o_q;
    addr_d  = addr_q;
    ready_d = 1'b0;
    spo_d   = spo_q;

    case (state_d)
      ST_RD0, ST_RD1: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
        addr_d = {word_d, (state_d == ST_RD1)};
      end
      ST_WR0, ST_REL0: begin
        ce_n_d  = 1'b0;
        ub_n_d  = 1'b0;
        lb_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        we_n_d  = (state_d != ST_WR0);
        addr_d  = {word_d, 1'b0};
        dq_o_d  = wdata_d[31:16];
      end
      ST_WR1, ST_REL1: begin
        ce_n_d  = 1'b0;
        ub_n_d  = 1'b0;
        lb_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        we_n_d  = (state_d != ST_WR1);
        addr_d  = {word_d, 1'b1};
        dq_o_d  = wdata_d[15:0];
      end
      ST_DONE: ready_d = 1'b1;
      default: ;
    endcase

    // Sample the SRAM on the last cycle of each read half.
    if (state_q == ST_RD0 && wait_done) spo_d[31:16] = sram_dq_i;
    if (state_q == ST_RD1 && wait_done) spo_d[15:0]  = sram_dq_i;
  end

  assign spo        = spo_q;
  assign ready      = ready_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule
`default_nettype wire
